sync_fifo_axi_drain: RTL



---
 rtl/sync_fifo_axi_drain.sv | 91 +++++++++
 1 files changed

// File: rtl/sync_fifo_axi_drain.sv
// sync_fifo_axi_drain: AXI4-Lite read master that polls a FIFO register block's level and re-emits popped words as a stream.
module sync_fifo_axi_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int POLL_GAP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           words_out
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  localparam logic [2:0] IDLE = 3'd0, POLL_AR = 3'd1, POLL_R = 3'd2, GAP = 3'd3,
                         DATA_AR = 3'd4, DATA_R = 3'd5, OUT = 3'd6;
  logic [2:0] state;
  logic [LW-1:0] remaining, level;
  logic [GW-1:0] gap_cnt;
  // AR/R controls decode straight from the state register, so arvalid never depends on arready
  assign level = m_axi_rdata[16 +: LW];
  assign m_axi_arprot = 3'b000;
  assign m_axi_arvalid = state == POLL_AR || state == DATA_AR;
  assign m_axi_araddr = state == POLL_AR ? BASE_ADDR + ADDR_WIDTH'(4) : BASE_ADDR;
  assign m_axi_rready = state == POLL_R || state == DATA_R;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      err <= 1'b0;
      words_out <= '0;
      remaining <= '0;
      gap_cnt <= '0;
    end else
      case (state)
        IDLE: if (enable) state <= POLL_AR;
        POLL_AR: if (m_axi_arready) state <= POLL_R;
        POLL_R:
          if (m_axi_rvalid) begin
            gap_cnt <= '0;
            if (m_axi_rresp != 2'b00) begin
              err <= 1'b1;
              state <= GAP;
            end else if (level == '0 || m_axi_rdata[0]) state <= GAP;
            else begin
              remaining <= level;
              state <= DATA_AR;
            end
          end
        GAP:
          if (gap_cnt == GW'(POLL_GAP - 1)) state <= enable ? POLL_AR : IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        DATA_AR: if (m_axi_arready) state <= DATA_R;
        DATA_R:
          if (m_axi_rvalid) begin
            if (m_axi_rresp != 2'b00) begin
              err <= 1'b1;
              remaining <= '0;
              state <= POLL_AR;
            end else begin
              m_axis_tdata <= m_axi_rdata;
              m_axis_tvalid <= 1'b1;
              state <= OUT;
            end
          end
        OUT:
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            words_out <= words_out + 32'd1;
            remaining <= remaining - LW'(1);
            state <= !enable ? IDLE : remaining > LW'(1) ? DATA_AR : POLL_AR;
          end
        default: state <= IDLE;
      endcase
endmodule
